// File: rtl/nios2os_multi_timer_if.sv
// Avalon-MM slave bus bundle for the multi-channel interval timer.
// Handshake: a write is accepted on any clk edge where chipselect & ~write_n;
// a read is requested with chipselect & ~read_n and its data is on readdata
// after that same edge (one-cycle latency, no wait states, no backpressure).
interface nios2os_multi_timer_if #(
    parameter int AW = 4
);
    logic [AW-1:0] address;
    logic          chipselect;
    logic          write_n;
    logic          read_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nios2os_multi_timer.sv
// NUM_CH independent down-counting interval timers behind one Avalon-MM
// slave. Each channel has STATUS/CONTROL/PERIOD/SNAP registers and its own
// interrupt line. All channels share one prescaler tick.
module nios2os_multi_timer #(
    parameter int          NUM_CH         = 4,
    parameter int          COUNTER_W      = 32,
    parameter int          PRESCALE_W     = 8,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h000F423F
) (
    input  logic                 clk,
    input  logic                 reset,
    nios2os_multi_timer_if.slave bus,
    output logic                 irq,
    output logic [NUM_CH-1:0]    irq_vec
);
    // Channel field is at least one bit so the address is at least 3 bits.
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = CH_W + 2;

    localparam logic [COUNTER_W-1:0]  DEF_PERIOD = DEFAULT_PERIOD[COUNTER_W-1:0];
    // The divide register is not software-visible; divide by 1.
    localparam logic [PRESCALE_W-1:0] DIVIDER    = '0;

    logic [CH_W-1:0] ch_idx;
    logic [1:0]      offset;
    logic            wr_en;
    logic            rd_en;
    logic            tick;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic [31:0]     rd_mux;

    logic [31:0] rd_status [NUM_CH];
    logic [31:0] rd_ctrl   [NUM_CH];
    logic [31:0] rd_period [NUM_CH];
    logic [31:0] rd_snap   [NUM_CH];

    assign ch_idx = bus.address[AW-1:2];
    assign offset = bus.address[1:0];
    assign wr_en  = bus.chipselect & ~bus.write_n;
    assign rd_en  = bus.chipselect & ~bus.read_n;
    assign tick   = (pre_cnt == '0);

    // Shared prescaler: counts down from DIVIDER and reloads at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= DIVIDER;
        end else if (pre_cnt == '0) begin
            pre_cnt <= DIVIDER;
        end else begin
            pre_cnt <= pre_cnt - PRESCALE_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [COUNTER_W-1:0] counter;
        logic [COUNTER_W-1:0] period;
        logic [COUNTER_W-1:0] snap;
        logic                 to_flag;
        logic                 run;
        logic                 ito;
        logic                 cont;
        logic                 pend;   // PERIOD written last cycle: reload now
        logic                 sel;
        logic                 hit;

        assign sel = wr_en && (ch_idx == CH_W'(g));
        assign hit = !pend && run && tick && (counter == '0);

        // Channel state: force-reload beats stepping; timeout beats a TO
        // clear; START beats STOP; SNAP sees the pre-step counter value.
        always_ff @(posedge clk) begin
            if (reset) begin
                counter <= DEF_PERIOD;
                period  <= DEF_PERIOD;
                snap    <= '0;
                to_flag <= 1'b0;
                run     <= 1'b0;
                ito     <= 1'b0;
                cont    <= 1'b0;
                pend    <= 1'b0;
            end else begin
                if (pend) begin
                    counter <= period;
                    run     <= 1'b0;
                    pend    <= 1'b0;
                end else if (run && tick) begin
                    if (counter == '0) begin
                        counter <= period;
                        if (!cont) begin
                            run <= 1'b0;
                        end
                    end else begin
                        counter <= counter - COUNTER_W'(1);
                    end
                end

                if (sel && offset == 2'd0) begin
                    to_flag <= 1'b0;
                end
                if (hit) begin
                    to_flag <= 1'b1;
                end

                if (sel && offset == 2'd1) begin
                    ito  <= bus.writedata[0];
                    cont <= bus.writedata[1];
                    if (bus.writedata[3]) begin
                        run <= 1'b0;
                    end
                    if (bus.writedata[2]) begin
                        run <= 1'b1;
                    end
                end

                if (sel && offset == 2'd2) begin
                    period <= bus.writedata[COUNTER_W-1:0];
                    pend   <= 1'b1;
                end

                if (sel && offset == 2'd3) begin
                    snap <= counter;
                end
            end
        end

        assign irq_vec[g]   = to_flag & ito;
        assign rd_status[g] = {30'd0, run, to_flag};
        assign rd_ctrl[g]   = {30'd0, cont, ito};
        assign rd_period[g] = 32'(period);
        assign rd_snap[g]   = 32'(snap);
    end

    assign irq = |irq_vec;

    // Read mux; channel indices without a channel fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == CH_W'(i)) begin
                case (offset)
                    2'd0:    rd_mux = rd_status[i];
                    2'd1:    rd_mux = rd_ctrl[i];
                    2'd2:    rd_mux = rd_period[i];
                    default: rd_mux = rd_snap[i];
                endcase
            end
        end
    end

    // Registered read data, one cycle after the read request.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
        end else if (rd_en) begin
            bus.readdata <= rd_mux;
        end else begin
            bus.readdata <= '0;
        end
    end
endmodule
